// File: rtl/pio_pkg.sv
// Shared register map, STATUS bit positions and pulse FSM states for the pulse PIO.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
  localparam logic [1:0] ADDR_PULSE     = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse-length counter and IDLE/ACTIVE sequencer; busy spans exactly max(len,1) clocks.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done_pulse
);

  pulse_state_t     state;
  logic [CNT_W-1:0] count;

  // done_pulse marks the last active cycle, so the owner of the mask clears it on the same edge the FSM leaves ACTIVE.
  assign busy       = (state == ACTIVE);
  assign done_pulse = (state == ACTIVE) && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= (len == '0) ? '0 : len - CNT_W'(1);
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (count == '0) begin
            state <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM output port: software-level bits plus hardware-timed inversion pulses.
// Define PIO_PULSE_IRQ_EN to add the sticky done flag (STATUS bit1) and the irq output.
module pio_pulse_out
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned      CNT_W         = 16,
  parameter int unsigned      PULSE_DEFAULT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef PIO_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] len_q;
  logic             wr_en;
  logic             start;
  logic             busy;
  logic             done_pulse;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign start        = wr_en && (address == ADDR_PULSE) && (writedata[WIDTH-1:0] != '0) && !busy;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      len_q  <= CNT_W'(PULSE_DEFAULT);
      mask_q <= '0;
    end else begin
      if (wr_en && (address == ADDR_DATA)) data_q <= writedata[WIDTH-1:0];
      if (wr_en && (address == ADDR_PULSE_LEN)) len_q <= writedata[CNT_W-1:0];
      if (start) begin
        mask_q <= writedata[WIDTH-1:0];
      end else if (done_pulse) begin
        mask_q <= '0;
      end
    end
  end

  // Both operands are flops, so writedata never reaches the pins combinationally.
  assign out_port = data_q ^ mask_q;

  pio_pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len_q),
    .busy      (busy),
    .done_pulse(done_pulse)
  );

`ifdef PIO_PULSE_IRQ_EN
  logic done_q;

  // Set has priority so a clear racing the pulse end cannot lose the event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else if (done_pulse) begin
      done_q <= 1'b1;
    end else if (wr_en && (address == ADDR_STATUS) && writedata[DONE_BIT]) begin
      done_q <= 1'b0;
    end
  end

  assign irq = done_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0] = data_q;
      ADDR_PULSE_LEN: readdata[CNT_W-1:0] = len_q;
      ADDR_PULSE:     readdata[WIDTH-1:0] = mask_q;
      ADDR_STATUS: begin
        readdata[BUSY_BIT] = busy;
`ifdef PIO_PULSE_IRQ_EN
        readdata[DONE_BIT] = done_q;
`endif
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_pulse_out.sv
// Bench for pio_pulse_out: directed vector table, hand-written pulse corner cases, then random traffic against a model.
// Build with PIO_PULSE_IRQ_EN defined to also exercise the done flag and irq.
module tb_pio_pulse_out;

  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef PIO_PULSE_IRQ_EN
  localparam logic [31:0] DONE_RD = 32'd2;
`else
  localparam logic [31:0] DONE_RD = 32'd0;
`endif

  typedef struct {
    bit          we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
`ifdef PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: register contents plus the number of clocks the current pulse still has to run.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_len;
  int         m_rem;
  bit         m_done;

  always #5 clk = ~clk;

  pio_pulse_out #(
    .WIDTH        (8),
    .RESET_VALUE  (RST_VAL),
    .CNT_W        (16),
    .PULSE_DEFAULT(1000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
`ifdef PIO_PULSE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    m_data = RST_VAL;
    m_len  = 1000;
    m_mask = 8'h00;
    m_rem  = 0;
    m_done = 1'b0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_data};
      2'd1:    return 32'(m_len);
      2'd2:    return {24'd0, m_mask};
      default: return {30'd0, m_done, (m_rem > 0)};
    endcase
  endfunction

  function automatic void modelStep(input bit wr, input logic [1:0] a, input logic [31:0] wd);
    bit ending;
    ending = (m_rem == 1);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_mask = 8'h00;
    end else if (wr && a == 2'd2 && wd[7:0] != 8'h00) begin
      m_mask = wd[7:0];
      m_rem  = (m_len == 0) ? 1 : m_len;
    end
    if (wr && a == 2'd0) m_data = wd[7:0];
    if (wr && a == 2'd1) m_len = int'(wd[15:0]);
`ifdef PIO_PULSE_IRQ_EN
    if (wr && a == 2'd3 && wd[1]) m_done = 1'b0;
    if (ending) m_done = 1'b1;
`else
    if (ending) m_done = 1'b0;
`endif
  endfunction

  // One bus cycle: drive at negedge, advance the model at posedge, compare #1 later.
  task automatic applyStimulus(input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    modelStep(cs && !wn, a, wd);
    #1;
    checkOutput("model out_port", {24'd0, out_port}, {24'd0, m_data ^ m_mask});
    checkOutput("model readdata", readdata, modelRead(a));
`ifdef PIO_PULSE_IRQ_EN
    checkOutput("model irq", {31'd0, irq}, {31'd0, m_done});
`endif
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    vec_t        vecs[18];
    int          op;
    bit          cs;
    logic [31:0] wd;

    vecs = '{
      '{1'b0, 2'd0, 32'h00, 8'hA5, 32'hA5},
      '{1'b0, 2'd1, 32'h00, 8'hA5, 32'd1000},
      '{1'b0, 2'd3, 32'h00, 8'hA5, 32'h0},
      '{1'b1, 2'd0, 32'h0F, 8'h0F, 32'h0F},
      '{1'b1, 2'd1, 32'h05, 8'h0F, 32'h5},
      '{1'b1, 2'd2, 32'h03, 8'h0C, 32'h3},
      '{1'b0, 2'd3, 32'h00, 8'h0C, 32'h1},
      '{1'b0, 2'd3, 32'h00, 8'h0C, 32'h1},
      '{1'b0, 2'd3, 32'h00, 8'h0C, 32'h1},
      '{1'b0, 2'd3, 32'h00, 8'h0C, 32'h1},
      '{1'b0, 2'd3, 32'h00, 8'h0F, DONE_RD},
      '{1'b1, 2'd3, 32'h02, 8'h0F, 32'h0},
      '{1'b1, 2'd1, 32'h00, 8'h0F, 32'h0},
      '{1'b1, 2'd2, 32'h80, 8'h8F, 32'h80},
      '{1'b0, 2'd2, 32'h00, 8'h0F, 32'h0},
      '{1'b1, 2'd3, 32'h02, 8'h0F, 32'h0},
      '{1'b1, 2'd2, 32'h00, 8'h0F, 32'h0},
      '{1'b0, 2'd3, 32'h00, 8'h0F, 32'h0}
    };

    // Reset values, held for several cycles while reset_n is low.
    modelReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = 2'(i);
      #1;
      checkOutput("reset out_port", {24'd0, out_port}, 32'hA5);
      checkOutput("reset readdata", readdata, (i == 0) ? 32'hA5 : (i == 1) ? 32'd1000 : 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].we, !vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d out_port", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
      checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
    end

    // 10-clock pulse on bit0: a second PULSE write is ignored, a DATA write shows through inverted.
    applyStimulus(1'b1, 1'b0, 2'd1, 32'd10);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h01);
    checkOutput("pulse10 start", {24'd0, out_port}, 32'h0E);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'hF0);
    checkOutput("pulse10 mask readback", readdata, 32'h01);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'hFF);
    checkOutput("pulse10 data write", {24'd0, out_port}, 32'hFE);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
      checkOutput("pulse10 held", {24'd0, out_port}, 32'hFE);
    end
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
    checkOutput("pulse10 end out_port", {24'd0, out_port}, 32'hFF);
    checkOutput("pulse10 end status", readdata, DONE_RD);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h2);

    // Reset asserted three clocks into a 10-clock pulse.
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h01);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
    checkOutput("midreset before", {24'd0, out_port}, 32'hFE);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset async out_port", {24'd0, out_port}, 32'hA5);
    checkOutput("midreset status", readdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
    checkOutput("after reset busy", readdata, 32'h0);
    checkOutput("after reset out_port", {24'd0, out_port}, 32'hA5);

`ifdef PIO_PULSE_IRQ_EN
    // A STATUS clear on the final pulse cycle loses to the done set.
    applyStimulus(1'b1, 1'b0, 2'd1, 32'd2);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h01);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0);
    checkOutput("irq low during pulse", {31'd0, irq}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h2);
    checkOutput("irq set wins", {31'd0, irq}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h2);
    checkOutput("irq cleared", {31'd0, irq}, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      wd = $urandom();
      cs = ($urandom_range(0, 7) != 0);
      case (op)
        0, 1: applyStimulus(cs, 1'b0, 2'd0, wd);
        2: applyStimulus(cs, 1'b0, 2'd1, {wd[31:16], 13'd0, wd[2:0]});
        3, 4: applyStimulus(cs, 1'b0, 2'd2, ($urandom_range(0, 4) == 0) ? {wd[31:8], 8'h00} : wd);
        5: applyStimulus(cs, 1'b0, 2'd3, wd);
        default: applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), wd);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
